// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch unit: register-file geometry and FSM states.
package operand_fetch_unit_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    // state | meaning
    // IDLE  | ready for a decode request
    // RD1   | read port driving src1, op1 captured at the edge
    // RD2   | read port driving src2, op2 captured at the edge
    // HOLD  | operands presented to execute, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_bypass.sv
// Combinational forward mux: same-cycle writeback data wins over the register-file read.
module fetch_bypass #(
    parameter int N      = operand_fetch_unit_pkg::DATA_W,
    parameter int ADDR_W = operand_fetch_unit_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [N-1:0]      rf_data,
    input  logic              wb_enable,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [N-1:0]      wb_data,
    output logic [N-1:0]      data_out
);

    assign data_out = (wb_enable && (wb_addr == src)) ? wb_data : rf_data;

endmodule

// File: rtl/operand_fetch_unit.sv
// Serialises one- or two-operand reads onto the single register-file read port,
// forwards writeback data, and holds the operands under a valid/ready handshake.
module operand_fetch_unit #(
    parameter int N      = operand_fetch_unit_pkg::DATA_W,
    parameter int ADDR_W = operand_fetch_unit_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_src1,
    input  logic [ADDR_W-1:0] req_src2,
    input  logic              req_two_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      op1,
    output logic [N-1:0]      op2,
    output logic              rf_read_enable,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [N-1:0]      rf_read_data,
    input  logic              wb_enable,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [N-1:0]      wb_data
);

    import operand_fetch_unit_pkg::*;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic              two_op_q;
    logic              out_valid_q;
    logic [N-1:0]      byp1;
    logic [N-1:0]      byp2;
    logic              hit1;
    logic              hit2;
    logic              accept;

    assign accept = (state == IDLE) && req_valid;
    assign hit1   = wb_enable && (wb_addr == src1_q);
    assign hit2   = wb_enable && (wb_addr == src2_q);

    fetch_bypass #(.N(N), .ADDR_W(ADDR_W)) u_bypass1 (
        .src       (src1_q),
        .rf_data   (rf_read_data),
        .wb_enable (wb_enable),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .data_out  (byp1)
    );

    fetch_bypass #(.N(N), .ADDR_W(ADDR_W)) u_bypass2 (
        .src       (src2_q),
        .rf_data   (rf_read_data),
        .wb_enable (wb_enable),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .data_out  (byp2)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and request-side handshake.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = RD1;
                end
            end
            RD1: begin
                state_nxt = two_op_q ? RD2 : HOLD;
            end
            RD2: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the accepted request; only one is ever outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src1_q   <= '0;
            src2_q   <= '0;
            two_op_q <= 1'b0;
        end else if (accept) begin
            src1_q   <= req_src1;
            src2_q   <= req_src2;
            two_op_q <= req_two_op;
        end
    end

    // Read port is registered from the next state so the address is stable for the
    // whole read cycle; RD1 is only ever entered from IDLE, hence req_src1 there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_read_enable <= 1'b0;
            rf_read_addr   <= '0;
        end else begin
            rf_read_enable <= (state_nxt == RD1) || (state_nxt == RD2);
            if (state_nxt == RD1) begin
                rf_read_addr <= req_src1;
            end else if (state_nxt == RD2) begin
                rf_read_addr <= src2_q;
            end
        end
    end

    // out_valid comes straight from a flop so it cannot glitch during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_nxt == HOLD);
        end
    end

    assign out_valid = out_valid_q;

    // Operand capture during the reads, then keep them coherent with writebacks while
    // stalled in HOLD. A one-operand fetch pins op2 at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op1 <= '0;
            op2 <= '0;
        end else begin
            case (state)
                RD1: begin
                    op1 <= byp1;
                    if (!two_op_q) begin
                        op2 <= '0;
                    end
                end
                RD2: begin
                    op2 <= byp2;
                end
                HOLD: begin
                    if (!out_ready) begin
                        if (hit1) begin
                            op1 <= wb_data;
                        end
                        if (two_op_q && hit2) begin
                            op2 <= wb_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Self-checking bench for operand_fetch_unit: directed scenarios plus randomized
// transactions scored against a transaction-level model of the fetch rules.
module tb_operand_fetch_unit;

    localparam int N  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_src1;
    logic [AW-1:0] req_src2;
    logic          req_two_op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  op1;
    logic [N-1:0]  op2;
    logic          rf_read_enable;
    logic [AW-1:0] rf_read_addr;
    logic [N-1:0]  rf_read_data;
    logic          wb_enable;
    logic [AW-1:0] wb_addr;
    logic [N-1:0]  wb_data;

    logic [N-1:0]  mem [0:7];

    int            n_chk  = 0;
    int            n_fail = 0;

    // Directed-write and random-write controls for the current transaction.
    int            dw_phase;
    logic [AW-1:0] dw_a;
    logic [N-1:0]  dw_d;
    bit            rnd_wb;
    logic [AW-1:0] cur_s1;
    logic [AW-1:0] cur_s2;

    operand_fetch_unit #(.N(N), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_src1       (req_src1),
        .req_src2       (req_src2),
        .req_two_op     (req_two_op),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .op1            (op1),
        .op2            (op2),
        .rf_read_enable (rf_read_enable),
        .rf_read_addr   (rf_read_addr),
        .rf_read_data   (rf_read_data),
        .wb_enable      (wb_enable),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data)
    );

    always #5 clk = ~clk;

    // Register file stand-in: combinational read, write on the clock edge.
    assign rf_read_data = mem[rf_read_addr];
    always @(posedge clk) begin
        if (wb_enable) mem[wb_addr] <= wb_data;
    end

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [N-1:0] d);
        wb_enable = 1'b1;
        wb_addr   = a;
        wb_data   = d;
        tick();
        wb_enable = 1'b0;
    endtask

    // Drive the writeback snoop for one cycle of a transaction.
    task automatic set_wb(input int ph);
        int sel;
        if (ph == dw_phase) begin
            wb_enable = 1'b1;
            wb_addr   = dw_a;
            wb_data   = dw_d;
        end else if (rnd_wb) begin
            wb_enable = ($urandom_range(0, 1) == 1);
            sel       = int'($urandom_range(0, 2));
            wb_addr   = (sel == 0) ? cur_s1 : (sel == 1) ? cur_s2 : AW'($urandom_range(0, 7));
            wb_data   = N'($urandom);
        end else begin
            wb_enable = 1'b0;
        end
    endtask

    // One complete fetch. Expected operands: the register's value as it stands right
    // after its read edge (a same-edge writeback counts), then any writeback to that
    // source on a stalled HOLD edge replaces it.
    task automatic run_txn(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input bit two,
                           input int stall);
        logic [N-1:0] e1;
        logic [N-1:0] e2;
        cur_s1 = s1;
        cur_s2 = s2;

        check_val("idle_req_ready", 16'(req_ready), 16'd1);
        check_val("idle_out_valid", 16'(out_valid), 16'd0);
        req_valid  = 1'b1;
        req_src1   = s1;
        req_src2   = s2;
        req_two_op = two;
        out_ready  = 1'b0;
        set_wb(0);
        tick();

        req_valid  = rnd_wb ? ($urandom_range(0, 1) == 1) : 1'b0;
        req_src1   = AW'($urandom_range(0, 7));
        req_src2   = AW'($urandom_range(0, 7));
        req_two_op = ($urandom_range(0, 1) == 1);

        check_val("rd1_enable", 16'(rf_read_enable), 16'd1);
        check_val("rd1_addr", 16'(rf_read_addr), 16'(s1));
        check_val("rd1_out_valid", 16'(out_valid), 16'd0);
        check_val("rd1_req_ready", 16'(req_ready), 16'd0);
        set_wb(1);
        e1 = (wb_enable && wb_addr == s1) ? wb_data : mem[s1];
        tick();

        if (two) begin
            check_val("rd2_enable", 16'(rf_read_enable), 16'd1);
            check_val("rd2_addr", 16'(rf_read_addr), 16'(s2));
            check_val("rd2_out_valid", 16'(out_valid), 16'd0);
            set_wb(2);
            e2 = (wb_enable && wb_addr == s2) ? wb_data : mem[s2];
            tick();
        end else begin
            e2 = '0;
        end

        for (int k = 0; k <= stall; k++) begin
            out_ready = (k == stall);
            set_wb(3 + k);
            check_val("hold_out_valid", 16'(out_valid), 16'd1);
            check_val("hold_req_ready", 16'(req_ready), 16'd0);
            check_val("hold_enable", 16'(rf_read_enable), 16'd0);
            check_val("hold_op1", op1, e1);
            check_val("hold_op2", op2, e2);
            if (!out_ready && wb_enable) begin
                if (wb_addr == s1) e1 = wb_data;
                if (two && wb_addr == s2) e2 = wb_data;
            end
            tick();
        end

        out_ready = 1'b0;
        req_valid = 1'b0;
        wb_enable = 1'b0;
        check_val("done_out_valid", 16'(out_valid), 16'd0);
        check_val("done_req_ready", 16'(req_ready), 16'd1);
        check_val("done_op1", op1, e1);
        check_val("done_op2", op2, e2);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_src1   = '0;
        req_src2   = '0;
        req_two_op = 1'b0;
        out_ready  = 1'b0;
        wb_enable  = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        dw_phase   = -1;
        dw_a       = '0;
        dw_d       = '0;
        rnd_wb     = 1'b0;
        cur_s1     = '0;
        cur_s2     = '0;

        // Reset held for three cycles.
        repeat (3) tick();
        check_val("rst_op1", op1, 16'h0000);
        check_val("rst_op2", op2, 16'h0000);
        check_val("rst_out_valid", 16'(out_valid), 16'd0);
        check_val("rst_req_ready", 16'(req_ready), 16'd1);
        check_val("rst_enable", 16'(rf_read_enable), 16'd0);
        check_val("rst_addr", 16'(rf_read_addr), 16'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) write_reg(AW'(i), N'($urandom));
        write_reg(3'd2, 16'h1234);
        write_reg(3'd5, 16'hBEEF);
        write_reg(3'd7, 16'h00FF);
        write_reg(3'd3, 16'h0001);
        write_reg(3'd4, 16'h0000);

        // Two-operand fetch.
        run_txn(3'd2, 3'd5, 1'b1, 0);
        check_val("two_op1", op1, 16'h1234);
        check_val("two_op2", op2, 16'hBEEF);

        // One-operand fetch.
        run_txn(3'd7, 3'd5, 1'b0, 0);
        check_val("one_op1", op1, 16'h00FF);
        check_val("one_op2", op2, 16'h0000);

        // Same-cycle writeback bypass in RD1.
        dw_phase = 1; dw_a = 3'd3; dw_d = 16'hA5A5;
        run_txn(3'd3, 3'd1, 1'b0, 0);
        check_val("bypass_op1", op1, 16'hA5A5);

        // Back-pressure with a writeback to src2 during HOLD.
        dw_phase = 5; dw_a = 3'd4; dw_d = 16'h7777;
        run_txn(3'd1, 3'd4, 1'b1, 5);
        check_val("coh_op2", op2, 16'h7777);
        dw_phase = -1;

        // Same source twice.
        run_txn(3'd5, 3'd5, 1'b1, 1);
        check_val("same_src_eq", op1, op2);

        // Reset dropped during RD2.
        req_valid = 1'b1; req_src1 = 3'd6; req_src2 = 3'd2; req_two_op = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check_val("mid_rd2_addr", 16'(rf_read_addr), 16'd2);
        rst = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 16'(out_valid), 16'd0);
        check_val("mid_rst_req_ready", 16'(req_ready), 16'd1);
        check_val("mid_rst_op1", op1, 16'h0000);
        check_val("mid_rst_op2", op2, 16'h0000);
        check_val("mid_rst_enable", 16'(rf_read_enable), 16'd0);
        tick();
        check_val("mid_rst_hold_valid", 16'(out_valid), 16'd0);
        rst = 1'b1;
        tick();
        run_txn(3'd2, 3'd7, 1'b1, 0);

        // Randomized transactions with random snooped writebacks and stalls.
        rnd_wb = 1'b1;
        for (int t = 0; t < 80; t++) begin
            run_txn(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 1), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
